fetch_line_ibuffer: RTL and testbench
=====================================

Name: fetch_line_ibuffer

Overview:
- Parametrised instruction buffer between the fetch arbiter and the decoder.
- Accepts one cache line plus its fetch PC. Unpacks the line into 32-bit instructions at up to ENQ_WIDTH per cycle, starting at the PC's slot.
- Queues each instruction with its PC in a circular FIFO. Presents up to DEQ_WIDTH oldest entries per cycle for multi-issue decode.
- Supports a single-cycle flush for redirect.

Parameters:
- PC_WIDTH, 48, PC width in bits.
- LINE_BITS, 512, fetched line width. SLOTS = LINE_BITS/32; LOFF = log2(LINE_BITS/8).
- DEPTH, 16, FIFO entries. Power of 2, at least max(ENQ_WIDTH, DEQ_WIDTH).
- ENQ_WIDTH, 4, instructions moved from line register to FIFO per cycle.
- DEQ_WIDTH, 2, dequeue ports.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  redirect; discard all buffered state
- line_valid  in  1  line_data/line_pc valid
- line_ready  out  1  line register can accept a line this cycle
- line_data  in  LINE_BITS  line; slot i = bits [32i+31:32i]
- line_pc  in  PC_WIDTH  fetch PC, 4-byte aligned; first slot = line_pc[LOFF-1:2]
- deq_valid  out  DEQ_WIDTH  bit i set when entry head+i exists
- deq_inst  out  DEQ_WIDTH*32  instruction of entry head+i, in lane i
- deq_pc  out  DEQ_WIDTH*PC_WIDTH  PC of entry head+i, in lane i
- deq_take  in  clog2(DEQ_WIDTH+1)  entries consumed this cycle
- count  out  clog2(DEPTH+1)  occupied entries
- empty  out  1  count==0

Behaviour:
- Reset (async, reset_n=0):
  - head=tail=count=0, state IDLE.
  - deq_valid=0, empty=1, line_ready=1. deq_inst/deq_pc=0.
- FSM IDLE / UNPACK. Line register holds data, base = line_pc[PC_WIDTH-1:LOFF], slot pointer sp.
- Accept when line_valid && line_ready && !flush:
  - load line register; sp = line_pc[LOFF-1:2]; state goes to UNPACK.
- In UNPACK, each cycle:
  - moved = min(ENQ_WIDTH, SLOTS-sp, DEPTH-count). count is the start-of-cycle value; same-cycle dequeues do not free space.
  - Slots sp..sp+moved-1 are written at tail, in order. PC of each = {base, slot, 2'b00}.
  - sp += moved. If sp reaches SLOTS, state goes to IDLE.
- line_ready = !flush && (IDLE || (UNPACK && moved == SLOTS-sp)). Back-to-back lines are allowed with no bubble.
- Latency: line accepted in cycle T; first instructions are visible on deq_valid in cycle T+2.
- Dequeue:
  - deq_valid[i] = (count > i). Lanes are combinational from FIFO storage.
  - deq_take must be ≤ popcount(deq_valid); a violation is an assertion failure.
  - head += deq_take, mod DEPTH.
- count_next = count + moved - deq_take. Pointers wrap mod DEPTH.
- Full (count==DEPTH): moved=0 and UNPACK stalls. Dequeue still works.
- Empty: deq_valid=0. deq_take must be 0.
- Flush has priority over everything in its cycle:
  - the next cycle has count=0, head=tail=0, state IDLE, deq_valid=0;
  - no line is accepted and no enqueue/dequeue takes effect in the flush cycle;
  - a line already in UNPACK is dropped.
- Reset asserted mid-UNPACK: immediate return to the reset state. The line is lost.

Test Plan:
- Reset -> empty=1, count=0, deq_valid=0, line_ready=1.
- Line at line_pc=0x80000000, slot i word = 0x1000+i, deq_take=0, accepted cycle T -> count 4/8/12/16 at T+2..T+5; line_ready=1 during T+4; lane0 = 0x1000 @0x80000000, lane1 = 0x1001 @0x80000004.
- line_pc=0x80000038 -> exactly 2 entries: 0x100E @0x80000038, 0x100F @0x8000003C; FSM back to IDLE after one UNPACK cycle.
- FIFO full (16), second line accepted and stalled -> deq_take=2 at cycle C -> count 14 at C+1; 2 moved in C+1 -> count 16 at C+2; PCs continue in order.
- Flush during UNPACK with count=6 -> next cycle count=0, empty=1, line_ready=1; old instructions never reappear.
- flush=1 with line_valid=1 same cycle -> line not accepted (line_ready=0); head/tail wrap verified over 40 enqueue/dequeue cycles with DEQ_WIDTH=2, ENQ_WIDTH=4, order preserved.

Source files
------------

// File: rtl/fetch_line_ibuffer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_line_ibuffer
//  Purpose  : Instruction buffer between fetch arbiter and decoder. Holds one
//             fetched line, unpacks it into 32-bit instructions (up to
//             ENQ_WIDTH per cycle, starting at the fetch PC's slot) into a
//             circular FIFO, and presents the DEQ_WIDTH oldest entries to a
//             multi-issue decoder. Single-cycle flush for redirects.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_line_ibuffer #(
    parameter int PC_WIDTH  = 48,
    parameter int LINE_BITS = 512,
    parameter int DEPTH     = 16,
    parameter int ENQ_WIDTH = 4,
    parameter int DEQ_WIDTH = 2
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            flush,
    input  logic                            line_valid,
    output logic                            line_ready,
    input  logic [LINE_BITS-1:0]            line_data,
    input  logic [PC_WIDTH-1:0]             line_pc,
    output logic [DEQ_WIDTH-1:0]            deq_valid,
    output logic [DEQ_WIDTH*32-1:0]         deq_inst,
    output logic [DEQ_WIDTH*PC_WIDTH-1:0]   deq_pc,
    input  logic [$clog2(DEQ_WIDTH+1)-1:0]  deq_take,
    output logic [$clog2(DEPTH+1)-1:0]      count,
    output logic                            empty
);

    localparam int c_SLOTS = LINE_BITS / 32;
    localparam int c_LOFF  = $clog2(LINE_BITS / 8);
    localparam int c_SPW   = $clog2(c_SLOTS);
    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_CW    = $clog2(DEPTH + 1);
    localparam int c_BW    = PC_WIDTH - c_LOFF;
    // Wide enough for slot/space/move arithmetic without overflow.
    localparam int c_MW    = $clog2(c_SLOTS + DEPTH + ENQ_WIDTH + 1) + 1;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_UNPACK = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_nxt;
    logic [LINE_BITS-1:0]  r_line;
    logic [c_BW-1:0]       r_base;
    logic [c_SPW-1:0]      r_sp;
    logic [c_AW-1:0]       r_head;
    logic [c_AW-1:0]       r_tail;
    logic [c_CW-1:0]       r_count;

    logic [31:0]           r_mem_inst [DEPTH];
    logic [PC_WIDTH-1:0]   r_mem_pc   [DEPTH];

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [c_MW-1:0]       w_rem;
    logic [c_MW-1:0]       w_space;
    logic [c_MW-1:0]       w_moved;
    logic                  w_unpack_done;
    logic                  w_accept;
    logic [c_CW-1:0]       w_avail;

    logic [31:0]           w_slot_word [c_SLOTS];

    logic                  w_wr_en   [ENQ_WIDTH];
    logic [c_AW-1:0]       w_wr_idx  [ENQ_WIDTH];
    logic [c_SPW-1:0]      w_wr_slot [ENQ_WIDTH];
    logic [31:0]           w_wr_inst [ENQ_WIDTH];
    logic [PC_WIDTH-1:0]   w_wr_pc   [ENQ_WIDTH];

    // Split the held line into addressable 32-bit slots.
    for (genvar s = 0; s < c_SLOTS; s++) begin : g_slot
        assign w_slot_word[s] = r_line[32*s +: 32];
    end

    // Instructions moved this cycle: bounded by enqueue width, slots left in
    // the line and free FIFO entries (start-of-cycle count; dequeues in the
    // same cycle do not free space early).
    always_comb begin
        w_rem   = c_MW'(c_SLOTS) - c_MW'(r_sp);
        w_space = c_MW'(DEPTH) - c_MW'(r_count);
        w_moved = '0;
        if (r_state == S_UNPACK) begin
            w_moved = c_MW'(ENQ_WIDTH);
            if (w_rem < w_moved) begin
                w_moved = w_rem;
            end
            if (w_space < w_moved) begin
                w_moved = w_space;
            end
        end
    end

    // The line register frees up in the same cycle its last slots leave, so
    // a following line can be taken without a bubble.
    assign w_unpack_done = (r_state == S_UNPACK) && (w_moved == w_rem);
    assign line_ready    = !flush && ((r_state == S_IDLE) || w_unpack_done);
    assign w_accept      = line_valid && line_ready;

    // Next-state logic: flush wins, then a newly accepted line, then the end
    // of the current line.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else if (w_accept) begin
            w_state_nxt = S_UNPACK;
        end else if (w_unpack_done) begin
            w_state_nxt = S_IDLE;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Line register and slot pointer: load on accept, advance while unpacking.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_line <= '0;
            r_base <= '0;
            r_sp   <= '0;
        end else if (w_accept) begin
            r_line <= line_data;
            r_base <= line_pc[PC_WIDTH-1:c_LOFF];
            r_sp   <= line_pc[c_LOFF-1:2];
        end else if (!flush && (r_state == S_UNPACK)) begin
            r_sp   <= r_sp + c_SPW'(w_moved);
        end
    end

    // FIFO pointers and occupancy; flush returns everything to empty.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + c_AW'(deq_take);
            r_tail  <= r_tail + c_AW'(w_moved);
            r_count <= r_count + c_CW'(w_moved) - c_CW'(deq_take);
        end
    end

    // Per-lane enqueue data: slot sp+k goes to FIFO entry tail+k.
    always_comb begin
        for (int k = 0; k < ENQ_WIDTH; k++) begin
            w_wr_slot[k] = r_sp + c_SPW'(k);
            w_wr_en[k]   = !flush && (c_MW'(k) < w_moved);
            w_wr_idx[k]  = r_tail + c_AW'(k);
            w_wr_inst[k] = w_slot_word[w_wr_slot[k]];
            w_wr_pc[k]   = {r_base, w_wr_slot[k], 2'b00};
        end
    end

    // FIFO storage; contents are only observable through valid lanes, so no
    // reset is needed here.
    always_ff @(posedge clock) begin
        for (int k = 0; k < ENQ_WIDTH; k++) begin
            if (w_wr_en[k]) begin
                r_mem_inst[w_wr_idx[k]] <= w_wr_inst[k];
                r_mem_pc[w_wr_idx[k]]   <= w_wr_pc[k];
            end
        end
    end

    // Dequeue lanes: lane i shows entry head+i, forced to zero when absent.
    for (genvar i = 0; i < DEQ_WIDTH; i++) begin : g_lane
        logic [c_AW-1:0] w_idx;
        assign w_idx                          = r_head + c_AW'(i);
        assign deq_valid[i]                   = (r_count > c_CW'(i));
        assign deq_inst[32*i +: 32]           = deq_valid[i] ? r_mem_inst[w_idx] : '0;
        assign deq_pc[PC_WIDTH*i +: PC_WIDTH] = deq_valid[i] ? r_mem_pc[w_idx]   : '0;
    end

    assign count = r_count;
    assign empty = (r_count == '0);

    // Number of lanes the decoder may legally consume this cycle.
    assign w_avail = (r_count > c_CW'(DEQ_WIDTH)) ? c_CW'(DEQ_WIDTH) : r_count;

    a_deq_take_legal: assert property (
        @(posedge clock) disable iff (!reset_n) (c_CW'(deq_take) <= w_avail));

    a_line_pc_aligned: assert property (
        @(posedge clock) disable iff (!reset_n) (line_valid |-> (line_pc[1:0] == 2'b00)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_line_ibuffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_line_ibuffer
//  Purpose  : Scoreboard bench for fetch_line_ibuffer. Stimulus pushes every
//             accepted instruction into an expected queue and tracks occupancy
//             with a slot/entry counting model; a monitor compares the
//             presented lanes against the queue and retires taken entries.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_line_ibuffer;

    localparam int PC_WIDTH  = 48;
    localparam int LINE_BITS = 512;
    localparam int DEPTH     = 16;
    localparam int ENQ_WIDTH = 4;
    localparam int DEQ_WIDTH = 2;
    localparam int SLOTS     = LINE_BITS / 32;

    logic                          clock = 1'b0;
    logic                          reset_n = 1'b0;
    logic                          flush = 1'b0;
    logic                          line_valid = 1'b0;
    logic                          line_ready;
    logic [LINE_BITS-1:0]          line_data = '0;
    logic [PC_WIDTH-1:0]           line_pc = '0;
    logic [DEQ_WIDTH-1:0]          deq_valid;
    logic [DEQ_WIDTH*32-1:0]       deq_inst;
    logic [DEQ_WIDTH*PC_WIDTH-1:0] deq_pc;
    logic [1:0]                    deq_take = '0;
    logic [4:0]                    count;
    logic                          empty;

    fetch_line_ibuffer #(
        .PC_WIDTH (PC_WIDTH),
        .LINE_BITS(LINE_BITS),
        .DEPTH    (DEPTH),
        .ENQ_WIDTH(ENQ_WIDTH),
        .DEQ_WIDTH(DEQ_WIDTH)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .line_valid(line_valid),
        .line_ready(line_ready),
        .line_data (line_data),
        .line_pc   (line_pc),
        .deq_valid (deq_valid),
        .deq_inst  (deq_inst),
        .deq_pc    (deq_pc),
        .deq_take  (deq_take),
        .count     (count),
        .empty     (empty)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0]         inst;
        logic [PC_WIDTH-1:0] pc;
    } ent_t;

    ent_t exp_q[$];      // every instruction not yet retired, oldest first
    int   occ  = 0;      // model: entries in the FIFO
    int   pend = 0;      // model: slots still waiting in the line register
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [LINE_BITS-1:0] rand_line();
        logic [LINE_BITS-1:0] d;
        for (int i = 0; i < SLOTS; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [PC_WIDTH-1:0] rand_pc();
        logic [PC_WIDTH-1:0] p;
        p = PC_WIDTH'({$urandom, $urandom});
        p[1:0] = 2'b00;
        return p;
    endfunction

    // One clock cycle: drive inputs, check occupancy-level outputs against the
    // counting model, then advance the model at the clock edge.
    task automatic do_cycle(input bit lv, input logic [PC_WIDTH-1:0] pc,
                            input logic [LINE_BITS-1:0] data, input bit fl, input int take);
        int te, mv;
        bit rdy;
        logic [DEQ_WIDTH-1:0] ev;
        @(negedge clock);
        te = imin(take, imin(occ, DEQ_WIDTH));
        line_valid = lv;
        line_pc    = pc;
        line_data  = data;
        flush      = fl;
        deq_take   = 2'(te);
        mv  = (pend > 0) ? imin(ENQ_WIDTH, imin(pend, DEPTH - occ)) : 0;
        rdy = !fl && ((pend == 0) || (mv == pend));
        for (int i = 0; i < DEQ_WIDTH; i++) ev[i] = (occ > i);
        #1;
        check("line_ready", 64'(line_ready), 64'(rdy));
        check("count", 64'(count), 64'(occ));
        check("empty", 64'(empty), 64'(occ == 0));
        check("deq_valid", 64'(deq_valid), 64'(ev));
        @(posedge clock);
        if (fl) begin
            occ = 0;
            pend = 0;
            exp_q.delete();
        end else begin
            occ  = occ + mv - te;
            pend = pend - mv;
            if (lv && rdy) begin
                int s0;
                s0   = int'(pc[5:2]);
                pend = SLOTS - s0;
                for (int s = s0; s < SLOTS; s++) begin
                    ent_t e;
                    e.inst = data[32*s +: 32];
                    e.pc   = {pc[PC_WIDTH-1:6], 4'(s), 2'b00};
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic idle_cycles(input int n, input int take);
        for (int i = 0; i < n; i++) do_cycle(1'b0, '0, '0, 1'b0, take);
    endtask

    // Monitor: compare each presented lane with the expected queue and retire
    // entries the decoder takes on non-flush cycles.
    initial begin
        logic [DEQ_WIDTH-1:0] v;
        int t;
        bit f;
        forever begin
            @(negedge clock);
            #2;
            if (reset_n) begin
                v = deq_valid;
                t = int'(deq_take);
                f = flush;
                for (int i = 0; i < DEQ_WIDTH; i++) begin
                    if (v[i]) begin
                        if (i < exp_q.size()) begin
                            check("lane_inst", 64'(deq_inst[32*i +: 32]), 64'(exp_q[i].inst));
                            check("lane_pc", 64'(deq_pc[PC_WIDTH*i +: PC_WIDTH]), 64'(exp_q[i].pc));
                        end else begin
                            check("scoreboard_underflow", 64'(i), 64'(exp_q.size()));
                        end
                    end
                end
                @(posedge clock);
                if (!f && reset_n) begin
                    for (int k = 0; k < t; k++) begin
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [LINE_BITS-1:0] seq_line;
        for (int i = 0; i < SLOTS; i++) seq_line[32*i +: 32] = 32'h1000 + 32'(i);

        // Reset values
        #2;
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_count", 64'(count), 64'd0);
        check("rst_deq_valid", 64'(deq_valid), 64'd0);
        check("rst_line_ready", 64'(line_ready), 64'd1);
        check("rst_deq_inst", 64'(deq_inst), 64'd0);
        check("rst_deq_pc", 64'(deq_pc[PC_WIDTH-1:0]), 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Full line from slot 0 with no dequeue: fills to 16, then a second
        // line is accepted and stalls until the decoder frees space.
        do_cycle(1'b1, 48'h0000_8000_0000, seq_line, 1'b0, 0);
        idle_cycles(5, 0);
        do_cycle(1'b1, 48'h0000_8000_0040, rand_line(), 1'b0, 0);
        idle_cycles(2, 0);
        do_cycle(1'b0, '0, '0, 1'b0, 2);
        idle_cycles(3, 0);
        idle_cycles(20, 2);

        // Line starting at slot 14: exactly two entries.
        do_cycle(1'b1, 48'h0000_8000_0038, seq_line, 1'b0, 0);
        idle_cycles(3, 0);
        idle_cycles(3, 2);

        // Flush during UNPACK, then flush together with a valid line.
        do_cycle(1'b1, 48'h0000_8000_0000, rand_line(), 1'b0, 0);
        idle_cycles(1, 0);
        do_cycle(1'b0, '0, '0, 1'b1, 0);
        do_cycle(1'b1, 48'h0000_9000_0000, rand_line(), 1'b1, 0);
        idle_cycles(3, 1);

        // Randomised phases: balanced, fill-heavy, drain-heavy, flush-heavy.
        for (int ph = 0; ph < 4; ph++) begin
            int lvp, fp, tmax;
            case (ph)
                0: begin lvp = 50; fp = 2;  tmax = 2; end
                1: begin lvp = 80; fp = 1;  tmax = 1; end
                2: begin lvp = 20; fp = 2;  tmax = 2; end
                default: begin lvp = 60; fp = 10; tmax = 2; end
            endcase
            for (int c = 0; c < 400; c++) begin
                do_cycle($urandom_range(0, 99) < lvp, rand_pc(), rand_line(),
                         $urandom_range(0, 99) < fp, $urandom_range(0, tmax));
            end
        end

        // Reset asserted mid-UNPACK drops everything immediately.
        do_cycle(1'b1, 48'h0000_8000_0000, rand_line(), 1'b0, 0);
        idle_cycles(1, 0);
        @(negedge clock);
        line_valid = 1'b0;
        flush      = 1'b0;
        deq_take   = '0;
        reset_n    = 1'b0;
        #1;
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_empty", 64'(empty), 64'd1);
        check("midrst_deq_valid", 64'(deq_valid), 64'd0);
        check("midrst_line_ready", 64'(line_ready), 64'd1);
        occ  = 0;
        pend = 0;
        exp_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        idle_cycles(3, 1);
        do_cycle(1'b1, 48'h0000_8000_0010, seq_line, 1'b0, 0);
        idle_cycles(8, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
